// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PC and IR, fetches over req/ack.
// Next PC comes from controlUnit's sigPCSrc; timeout is sticky.
module fetch_stage #(
  parameter int                  PC_WIDTH       = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC       = '0,
  parameter int                  TIMEOUT_CYCLES = 15
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enIF,
  input  logic [2:0]          sigPCSrc,
  input  logic [PC_WIDTH-1:0] branchTarget,
  input  logic [PC_WIDTH-1:0] jumpTarget,
  input  logic [PC_WIDTH-1:0] returnAddr,
  output logic                imemReq,
  output logic [PC_WIDTH-1:0] imemAddr,
  input  logic                imemAck,
  input  logic [31:0]         imemData,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pcPlus1,
  output logic [31:0]         instruction,
  output logic [5:0]          instructionCode,
  output logic                fetchDone,
  output logic                busy,
  output logic                fetchError
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] REQ   = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] ERROR = 2'd3;

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [1:0]          state;
  logic [CW-1:0]       waitCnt;
  logic                firstFetch;
  logic [PC_WIDTH-1:0] nextPc;
  logic [31:0]         ir;

  assign pcPlus1         = pc + PC_WIDTH'(1);
  assign imemAddr        = pc;
  assign busy            = (state == REQ) || (state == WAIT);
  // Request is decoded from state so reset drops it immediately.
  assign imemReq         = busy;
  assign instruction     = ir;
  assign instructionCode = ir[31:26];

  // Next-PC select; reserved encodings fall back to sequential.
  always_comb begin
    nextPc = pcPlus1;
    case (sigPCSrc)
      3'd1:    nextPc = branchTarget;
      3'd2:    nextPc = jumpTarget;
      3'd3:    nextPc = returnAddr;
      default: nextPc = pcPlus1;
    endcase
  end

  // Fetch FSM, PC/IR update and timeout tracking.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      ir         <= '0;
      fetchDone  <= 1'b0;
      fetchError <= 1'b0;
      firstFetch <= 1'b1;
      waitCnt    <= '0;
    end else begin
      fetchDone <= 1'b0;
      case (state)
        IDLE: begin
          if (enIF) begin
            if (!firstFetch) pc <= nextPc;
            firstFetch <= 1'b0;
            state      <= REQ;
          end
        end
        REQ: begin
          waitCnt <= '0;
          if (imemAck) begin
            ir        <= imemData;
            fetchDone <= 1'b1;
            state     <= IDLE;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imemAck) begin
            ir        <= imemData;
            fetchDone <= 1'b1;
            state     <= IDLE;
          end else if (waitCnt == LAST) begin
            fetchError <= 1'b1;
            state      <= ERROR;
          end else begin
            waitCnt <= waitCnt + CW'(1);
          end
        end
        ERROR: begin
          state <= ERROR;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage.
// Inputs change 1ns after the rising edge; outputs are read there too.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enIF = 1'b0;
  logic [2:0]  sigPCSrc = 3'd0;
  logic [31:0] branchTarget = '0;
  logic [31:0] jumpTarget = '0;
  logic [31:0] returnAddr = '0;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck = 1'b0;
  logic [31:0] imemData = '0;
  logic [31:0] pc;
  logic [31:0] pcPlus1;
  logic [31:0] instruction;
  logic [5:0]  instructionCode;
  logic        fetchDone;
  logic        busy;
  logic        fetchError;

  int checks = 0;
  int failures = 0;

  fetch_stage #(
    .PC_WIDTH(32),
    .RESET_PC(32'h0),
    .TIMEOUT_CYCLES(15)
  ) dut (
    .clock(clock),
    .reset(reset),
    .enIF(enIF),
    .sigPCSrc(sigPCSrc),
    .branchTarget(branchTarget),
    .jumpTarget(jumpTarget),
    .returnAddr(returnAddr),
    .imemReq(imemReq),
    .imemAddr(imemAddr),
    .imemAck(imemAck),
    .imemData(imemData),
    .pc(pc),
    .pcPlus1(pcPlus1),
    .instruction(instruction),
    .instructionCode(instructionCode),
    .fetchDone(fetchDone),
    .busy(busy),
    .fetchError(fetchError)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Launch one fetch from IDLE; ack arrives after `delay` ackless
  // cycles (0 = ack in REQ). Reports address, hold and done status.
  task automatic runFetch(
    input  logic [2:0]  src,
    input  int          delay,
    input  logic [31:0] data,
    output logic [31:0] addr,
    output logic        held,
    output logic        done
  );
    sigPCSrc = src;
    enIF = 1'b1;
    tick();
    enIF = 1'b0;
    addr = imemAddr;
    held = 1'b1;
    for (int i = 0; i < delay; i++) begin
      if (imemReq !== 1'b1 || imemAddr !== addr) held = 1'b0;
      tick();
    end
    if (imemReq !== 1'b1 || imemAddr !== addr) held = 1'b0;
    imemAck = 1'b1;
    imemData = data;
    tick();
    imemAck = 1'b0;
    done = fetchDone;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_req got req=%b busy=%b exp 0 0", imemReq, busy);
    end
    checks++;
    if (pc !== 32'h0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL rst_pc_ir got pc=%h ir=%h exp 0 0", pc, instruction);
    end
    checks++;
    if (fetchDone !== 1'b0 || fetchError !== 1'b0) begin
      failures++;
      $display("FAIL rst_flags got done=%b err=%b exp 0 0", fetchDone, fetchError);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_first_fetch;
    sigPCSrc = 3'd1;
    branchTarget = 32'h99;
    enIF = 1'b1;
    tick();
    enIF = 1'b0;
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL ff_req got req=%b addr=%h busy=%b exp 1 0 1", imemReq, imemAddr, busy);
    end
    tick();
    checks++;
    if (imemReq !== 1'b1 || fetchDone !== 1'b0) begin
      failures++;
      $display("FAIL ff_wait got req=%b done=%b exp 1 0", imemReq, fetchDone);
    end
    imemAck = 1'b1;
    imemData = 32'h0C41_0003;
    tick();
    imemAck = 1'b0;
    checks++;
    if (fetchDone !== 1'b1 || instruction !== 32'h0C41_0003) begin
      failures++;
      $display("FAIL ff_done got done=%b ir=%h exp 1 0c410003", fetchDone, instruction);
    end
    checks++;
    if (instructionCode !== 6'h03 || pc !== 32'h0 || imemReq !== 1'b0) begin
      failures++;
      $display("FAIL ff_code got code=%h pc=%h req=%b exp 03 0 0", instructionCode, pc, imemReq);
    end
    tick();
    checks++;
    if (fetchDone !== 1'b0) begin
      failures++;
      $display("FAIL ff_pulse got done=%b exp 0", fetchDone);
    end
  endtask

  task automatic test_next_pc;
    logic [31:0] a;
    logic h;
    logic d;
    jumpTarget = 32'h5;
    runFetch(3'd2, 1, 32'h1111_0000, a, h, d);
    checks++;
    if (a !== 32'h5 || pc !== 32'h5 || d !== 1'b1) begin
      failures++;
      $display("FAIL np_jump got addr=%h pc=%h done=%b exp 5 5 1", a, pc, d);
    end
    runFetch(3'd0, 0, 32'h2222_0000, a, h, d);
    checks++;
    if (a !== 32'h6 || instruction !== 32'h2222_0000) begin
      failures++;
      $display("FAIL np_seq got addr=%h ir=%h exp 6 22220000", a, instruction);
    end
    branchTarget = 32'h40;
    runFetch(3'd1, 1, 32'h3333_0000, a, h, d);
    checks++;
    if (a !== 32'h40) begin
      failures++;
      $display("FAIL np_branch got addr=%h exp 40", a);
    end
    returnAddr = 32'h11;
    runFetch(3'd3, 1, 32'h4444_0000, a, h, d);
    checks++;
    if (a !== 32'h11) begin
      failures++;
      $display("FAIL np_ret got addr=%h exp 11", a);
    end
    runFetch(3'd6, 1, 32'h5555_0000, a, h, d);
    checks++;
    if (a !== 32'h12 || pcPlus1 !== 32'h13) begin
      failures++;
      $display("FAIL np_rsvd got addr=%h pc1=%h exp 12 13", a, pcPlus1);
    end
  endtask

  task automatic test_delayed_ack;
    logic held;
    logic [31:0] a;
    sigPCSrc = 3'd0;
    enIF = 1'b1;
    tick();
    enIF = 1'b0;
    a = imemAddr;
    held = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (imemReq !== 1'b1 || imemAddr !== 32'h13) held = 1'b0;
      enIF = (i == 2);
      tick();
    end
    enIF = 1'b0;
    checks++;
    if (a !== 32'h13 || held !== 1'b1) begin
      failures++;
      $display("FAIL da_hold got addr=%h held=%b exp 13 1", a, held);
    end
    imemAck = 1'b1;
    imemData = 32'hFC00_00AA;
    tick();
    imemAck = 1'b0;
    checks++;
    if (fetchDone !== 1'b1 || instructionCode !== 6'h3F || pc !== 32'h13) begin
      failures++;
      $display("FAIL da_done got done=%b code=%h pc=%h exp 1 3f 13", fetchDone, instructionCode, pc);
    end
    tick();
    tick();
    checks++;
    if (fetchDone !== 1'b0 || busy !== 1'b0 || pc !== 32'h13) begin
      failures++;
      $display("FAIL da_noqueue got done=%b busy=%b pc=%h exp 0 0 13", fetchDone, busy, pc);
    end
  endtask

  task automatic test_wrap;
    logic [31:0] a;
    logic h;
    logic d;
    jumpTarget = 32'hFFFF_FFFF;
    runFetch(3'd2, 0, 32'h0, a, h, d);
    checks++;
    if (pc !== 32'hFFFF_FFFF || pcPlus1 !== 32'h0) begin
      failures++;
      $display("FAIL wr_top got pc=%h pc1=%h exp ffffffff 0", pc, pcPlus1);
    end
    runFetch(3'd0, 1, 32'h0, a, h, d);
    checks++;
    if (a !== 32'h0 || fetchError !== 1'b0) begin
      failures++;
      $display("FAIL wr_zero got addr=%h err=%b exp 0 0", a, fetchError);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] a;
    logic h;
    logic d;
    sigPCSrc = 3'd0;
    enIF = 1'b1;
    tick();
    enIF = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (fetchError !== 1'b0 || imemReq !== 1'b1) begin
      failures++;
      $display("FAIL to_early got err=%b req=%b exp 0 1", fetchError, imemReq);
    end
    tick();
    checks++;
    if (fetchError !== 1'b1 || imemReq !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL to_err got err=%b req=%b busy=%b exp 1 0 0", fetchError, imemReq, busy);
    end
    enIF = 1'b1;
    imemAck = 1'b1;
    imemData = 32'hBAD0_BAD0;
    tick();
    tick();
    enIF = 1'b0;
    imemAck = 1'b0;
    checks++;
    if (imemReq !== 1'b0 || pc !== 32'h1 || instruction !== 32'h0 || fetchDone !== 1'b0) begin
      failures++;
      $display("FAIL to_stuck got req=%b pc=%h ir=%h done=%b exp 0 1 0 0", imemReq, pc, instruction, fetchDone);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (fetchError !== 1'b0) begin
      failures++;
      $display("FAIL to_clear got err=%b exp 0", fetchError);
    end
    branchTarget = 32'h77;
    runFetch(3'd1, 1, 32'h0800_0001, a, h, d);
    checks++;
    if (a !== 32'h0 || d !== 1'b1 || instructionCode !== 6'h02) begin
      failures++;
      $display("FAIL to_refetch got addr=%h done=%b code=%h exp 0 1 02", a, d, instructionCode);
    end
  endtask

  task automatic test_reset_mid_wait;
    jumpTarget = 32'h20;
    sigPCSrc = 3'd2;
    enIF = 1'b1;
    tick();
    enIF = 1'b0;
    tick();
    checks++;
    if (imemReq !== 1'b1 || imemAddr !== 32'h20) begin
      failures++;
      $display("FAIL rm_wait got req=%b addr=%h exp 1 20", imemReq, imemAddr);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (imemReq !== 1'b0 || pc !== 32'h0 || instruction !== 32'h0) begin
      failures++;
      $display("FAIL rm_async got req=%b pc=%h ir=%h exp 0 0 0", imemReq, pc, instruction);
    end
    tick();
    reset = 1'b0;
    imemAck = 1'b1;
    imemData = 32'hDEAD_BEEF;
    tick();
    tick();
    imemAck = 1'b0;
    checks++;
    if (instruction !== 32'h0 || fetchDone !== 1'b0 || imemReq !== 1'b0) begin
      failures++;
      $display("FAIL rm_late got ir=%h done=%b req=%b exp 0 0 0", instruction, fetchDone, imemReq);
    end
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_next_pc();
    test_delayed_ack();
    test_wrap();
    test_timeout();
    test_reset_mid_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
